// File: rtl/bf_operand_feeder_if.sv
// rtl/bf_operand_feeder_if.sv - coefficient stream, twiddle ROM and operand bus of the butterfly feeder
interface bf_operand_feeder_if #(
    parameter int DATA_WIDTH = 12,
    parameter int TW_AW      = 8,
    parameter int SW         = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    tw_rd;
    logic [TW_AW-1:0]        tw_addr;
    logic [3*DATA_WIDTH-1:0] tw_data;
    logic [DATA_WIDTH-1:0]   u0;
    logic [DATA_WIDTH-1:0]   v0;
    logic [DATA_WIDTH-1:0]   u1;
    logic [DATA_WIDTH-1:0]   v1;
    logic [DATA_WIDTH-1:0]   wa1;
    logic [DATA_WIDTH-1:0]   wa2;
    logic [DATA_WIDTH-1:0]   wa3;
    logic                    op_valid;
    logic                    bf_out_valid;
    logic [SW-1:0]           stage_idx;
    logic                    done;
    logic                    err_range;

    modport master (
        output in_valid, in_data, tw_data,
        input  in_ready, tw_rd, tw_addr, u0, v0, u1, v1, wa1, wa2, wa3,
               op_valid, bf_out_valid, stage_idx, done, err_range
    );

    modport slave (
        input  in_valid, in_data, tw_data,
        output in_ready, tw_rd, tw_addr, u0, v0, u1, v1, wa1, wa2, wa3,
               op_valid, bf_out_valid, stage_idx, done, err_range
    );
endinterface

// File: rtl/bf_operand_feeder.sv
// rtl/bf_operand_feeder.sv - packs coefficients into butterfly operand groups and fetches twiddles; optional FEEDER_MOD_CHECK_EN
module bf_operand_feeder #(
    parameter int DATA_WIDTH = 12,
    parameter int Q          = 3329,
    parameter int NGROUPS    = 64,
    parameter int NSTAGES    = 4,
    parameter int TW_AW      = 8,
    parameter int BF_LAT     = 4
) (
    input  logic              clk,
    input  logic              rst,
    bf_operand_feeder_if.slave bus
);
    localparam int GW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int SW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
    localparam logic [DATA_WIDTH-1:0] QV = DATA_WIDTH'(Q);

    typedef enum logic [1:0] {FILL, FETCH, ISSUE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              fill_cnt;
    logic [GW-1:0]           group;
    logic [SW-1:0]           stage;
    logic [DATA_WIDTH-1:0]   u0_q;
    logic [DATA_WIDTH-1:0]   v0_q;
    logic [DATA_WIDTH-1:0]   u1_q;
    logic [DATA_WIDTH-1:0]   v1_q;
    logic [DATA_WIDTH-1:0]   wa1_q;
    logic [DATA_WIDTH-1:0]   wa2_q;
    logic [DATA_WIDTH-1:0]   wa3_q;
    logic [TW_AW-1:0]        addr_q;
    logic                    done_q;
    logic                    in_ready_c;
    logic                    tw_rd_c;
    logic                    op_valid_c;
    logic                    accept;
    logic                    issue;
    logic                    last_group;
    logic                    last_stage;
    logic                    over;
    logic [DATA_WIDTH-1:0]   word;

    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        tw_rd_c    = 1'b0;
        op_valid_c = 1'b0;
        case (state)
            FILL: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && fill_cnt == 2'd3) state_next = FETCH;
            end
            FETCH: begin
                tw_rd_c    = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                op_valid_c = 1'b1;
                state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    assign accept     = in_ready_c && bus.in_valid;
    assign issue      = op_valid_c;
    assign last_group = (group == GW'(NGROUPS - 1));
    assign last_stage = (stage == SW'(NSTAGES - 1));

`ifdef FEEDER_MOD_CHECK_EN
    logic err_q;

    // Inputs are below 2Q, so a single conditional subtraction reduces them.
    assign over = (bus.in_data >= QV);

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept && over) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_range = err_q;
`else
    assign over          = 1'b0;
    assign bus.err_range = 1'b0;
`endif

    assign word = bus.in_data - (over ? QV : '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FILL;
            fill_cnt <= '0;
            group    <= '0;
            stage    <= '0;
            u0_q     <= '0;
            v0_q     <= '0;
            u1_q     <= '0;
            v1_q     <= '0;
            wa1_q    <= '0;
            wa2_q    <= '0;
            wa3_q    <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= issue && last_group && last_stage;
            if (accept) begin
                case (fill_cnt)
                    2'd0:    u0_q <= word;
                    2'd1:    v0_q <= word;
                    2'd2:    u1_q <= word;
                    default: v1_q <= word;
                endcase
                fill_cnt <= fill_cnt + 2'd1;
                if (fill_cnt == 2'd3) begin
                    addr_q <= TW_AW'(stage) * TW_AW'(NGROUPS) + TW_AW'(group);
                end
            end
            if (issue) begin
                wa1_q <= bus.tw_data[DATA_WIDTH-1:0];
                wa2_q <= bus.tw_data[2*DATA_WIDTH-1:DATA_WIDTH];
                wa3_q <= bus.tw_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
                group <= last_group ? '0 : group + 1'b1;
                if (last_group) begin
                    stage <= last_stage ? '0 : stage + 1'b1;
                end
            end
        end
    end

    // ROM data lands in the ISSUE cycle; it is forwarded then and held afterwards.
    assign bus.wa1 = issue ? bus.tw_data[DATA_WIDTH-1:0]              : wa1_q;
    assign bus.wa2 = issue ? bus.tw_data[2*DATA_WIDTH-1:DATA_WIDTH]   : wa2_q;
    assign bus.wa3 = issue ? bus.tw_data[3*DATA_WIDTH-1:2*DATA_WIDTH] : wa3_q;

    assign bus.in_ready  = in_ready_c;
    assign bus.tw_rd     = tw_rd_c;
    assign bus.tw_addr   = addr_q;
    assign bus.op_valid  = op_valid_c;
    assign bus.u0        = u0_q;
    assign bus.v0        = v0_q;
    assign bus.u1        = u1_q;
    assign bus.v1        = v1_q;
    assign bus.stage_idx = stage;
    assign bus.done      = done_q;

    generate
        if (BF_LAT == 0) begin : g_no_lat
            assign bus.bf_out_valid = op_valid_c;
        end else begin : g_lat
            logic [BF_LAT-1:0] lat_sr;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    lat_sr <= '0;
                end else begin
                    lat_sr <= (lat_sr << 1) | BF_LAT'(op_valid_c);
                end
            end

            assign bus.bf_out_valid = lat_sr[BF_LAT-1];
        end
    endgenerate
endmodule

// File: tb/tb_bf_operand_feeder.sv
// tb/tb_bf_operand_feeder.sv - directed table and stream bench for bf_operand_feeder
module tb_bf_operand_feeder;
    localparam int DW    = 12;
    localparam int TW_AW = 8;
    localparam int NG    = 64;
    localparam int NS    = 4;
    localparam int BL    = 4;
    localparam int QM    = 3329;
`ifdef FEEDER_MOD_CHECK_EN
    localparam bit MODV = 1'b1;
`else
    localparam bit MODV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bf_operand_feeder_if #(.DATA_WIDTH(DW), .TW_AW(TW_AW), .SW(2)) bus ();

    bf_operand_feeder #(
        .DATA_WIDTH(DW), .Q(QM), .NGROUPS(NG), .NSTAGES(NS), .TW_AW(TW_AW), .BF_LAT(BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    function automatic logic [3*DW-1:0] rom(input logic [TW_AW-1:0] a);
        logic [DW-1:0] b;
        b = DW'(a);
        return {b + 12'd30, b + 12'd20, b + 12'd10};
    endfunction

    always @(posedge clk) begin : rom_p
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if (bus.tw_rd) bus.tw_data <= rom(bus.tw_addr);
        else           bus.tw_data <= r[3*DW-1:0];
    end

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    int               m_state;
    int               m_cnt;
    int               m_grp;
    logic [DW-1:0]    m_slot [4];
    logic [TW_AW-1:0] m_addr;
    logic [3*DW-1:0]  m_wa;
    logic [3:0]       m_hist;
    logic             m_done;
    logic             m_err;

    function automatic logic [DW-1:0] model_mod(input logic [DW-1:0] d);
        if (MODV && d >= DW'(QM)) return d - DW'(QM);
        return d;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_grp = 0; m_addr = '0; m_wa = '0;
        m_hist = '0; m_done = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
    endtask

    // Compare all outputs against the reference, drive inputs, advance one clock.
    task automatic cyc(input logic v, input logic [DW-1:0] d);
        chk("in_ready", 64'(bus.in_ready), 64'(m_state == 0));
        chk("tw_rd", 64'(bus.tw_rd), 64'(m_state == 1));
        if (m_state == 1) chk("tw_addr", 64'(bus.tw_addr), 64'(m_addr));
        chk("op_valid", 64'(bus.op_valid), 64'(m_state == 2));
        if (m_state == 2) begin
            chk("operands", 64'({bus.u0, bus.v0, bus.u1, bus.v1}),
                64'({m_slot[0], m_slot[1], m_slot[2], m_slot[3]}));
            chk("twiddles", 64'({bus.wa3, bus.wa2, bus.wa1}), 64'(rom(m_addr)));
            chk("stage_idx", 64'(bus.stage_idx), 64'(m_addr[7:6]));
        end else begin
            chk("twiddle_hold", 64'({bus.wa3, bus.wa2, bus.wa1}), 64'(m_wa));
        end
        chk("bf_out_valid", 64'(bus.bf_out_valid), 64'(m_hist[3]));
        chk("done", 64'(bus.done), 64'(m_done));
        chk("err_range", 64'(bus.err_range), 64'(m_err));
        if (bus.done === 1'b1) done_cnt++;

        bus.in_valid = v;
        bus.in_data  = d;

        if (!rst) begin
            model_reset();
        end else begin
            m_done = (m_state == 2) && (m_addr == 8'd255);
            m_hist = {m_hist[2:0], m_state == 2};
            case (m_state)
                0: if (v) begin
                    m_slot[m_cnt] = model_mod(d);
                    if (MODV && d >= DW'(QM)) m_err = 1'b1;
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_cnt   = 0;
                        m_addr  = TW_AW'(m_grp % 256);
                        m_state = 1;
                    end
                end
                1: m_state = 2;
                default: begin
                    m_wa    = rom(m_addr);
                    m_grp++;
                    m_state = 0;
                end
            endcase
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [DW-1:0] w [4];
        int            gap;
        logic [DW-1:0] e [4];
        logic [DW-1:0] ewa [3];
        logic          eerr;
    } vec_t;

    vec_t tbl [5];

    task automatic setv(input int i,
                        input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                        input logic [DW-1:0] w2, input logic [DW-1:0] w3, input int gap,
                        input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                        input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                        input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                        input logic [DW-1:0] a3, input logic ee);
        tbl[i].w[0] = w0; tbl[i].w[1] = w1; tbl[i].w[2] = w2; tbl[i].w[3] = w3;
        tbl[i].gap  = gap;
        tbl[i].e[0] = e0; tbl[i].e[1] = e1; tbl[i].e[2] = e2; tbl[i].e[3] = e3;
        tbl[i].ewa[0] = a1; tbl[i].ewa[1] = a2; tbl[i].ewa[2] = a3;
        tbl[i].eerr = ee;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got;
        int wv;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        setv(0, 1, 2, 3, 4, 0,          1, 2, 3, 4,          10, 20, 30, 1'b0);
        setv(1, 1, 2, 3, 4, 3,          1, 2, 3, 4,          11, 21, 31, 1'b0);
        setv(2, 100, 200, 3000, 3328, 0, 100, 200, 3000, 3328, 12, 22, 32, 1'b0);
`ifdef FEEDER_MOD_CHECK_EN
        setv(3, 3329, 4000, 5, 3328, 0, 0, 671, 5, 3328,     13, 23, 33, 1'b1);
        setv(4, 7, 6, 5, 4, 2,          7, 6, 5, 4,          14, 24, 34, 1'b1);
`else
        setv(3, 3329, 4000, 5, 3328, 0, 3329, 4000, 5, 3328, 13, 23, 33, 1'b0);
        setv(4, 7, 6, 5, 4, 2,          7, 6, 5, 4,          14, 24, 34, 1'b0);
`endif

        rst = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_flags", 64'({bus.op_valid, bus.bf_out_valid, bus.done, bus.tw_rd, bus.err_range}), 64'd0);
        chk("rst_operands", 64'({bus.u0, bus.v0, bus.u1, bus.v1}), 64'd0);
        chk("rst_twiddles", 64'({bus.wa3, bus.wa2, bus.wa1}), 64'd0);
        chk("rst_stage_addr", 64'({bus.stage_idx, bus.tw_addr}), 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, tbl[i].w[0]);
            cyc(1'b1, tbl[i].w[1]);
            for (int g = 0; g < tbl[i].gap; g++) cyc(1'b0, '0);
            cyc(1'b1, tbl[i].w[2]);
            cyc(1'b1, tbl[i].w[3]);
            got = 1'b0;
            for (int k = 0; k < 4 && !got; k++) begin
                if (bus.op_valid === 1'b1) got = 1'b1;
                else cyc(1'b0, '0);
            end
            chk("tbl_op_valid_seen", 64'(got), 64'd1);
            chk("tbl_operands", 64'({bus.u0, bus.v0, bus.u1, bus.v1}),
                64'({tbl[i].e[0], tbl[i].e[1], tbl[i].e[2], tbl[i].e[3]}));
            chk("tbl_twiddles", 64'({bus.wa3, bus.wa2, bus.wa1}),
                64'({tbl[i].ewa[2], tbl[i].ewa[1], tbl[i].ewa[0]}));
            chk("tbl_err_range", 64'(bus.err_range), 64'(tbl[i].eerr));
            cyc(1'b0, '0);
        end

        // Reset in the middle of group 5 while group 4 is still in the latency line.
        cyc(1'b1, 12'd11);
        cyc(1'b1, 12'd12);
        rst = 1'b0;
        cyc(1'b0, '0);
        chk("midrst_flags", 64'({bus.op_valid, bus.bf_out_valid, bus.done, bus.tw_rd, bus.err_range}), 64'd0);
        chk("midrst_operands", 64'({bus.u0, bus.v0, bus.u1, bus.v1}), 64'd0);
        chk("midrst_twiddles", 64'({bus.wa3, bus.wa2, bus.wa1}), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b1;
        repeat (6) cyc(1'b0, '0);

        // Full transform plus one group, in_valid held high throughout.
        done_cnt = 0;
        wv = 1;
        for (int c = 0; c < 257 * 6 + 20 && m_grp < 257; c++) begin
            bit acc;
            acc = (m_state == 0);
            cyc(1'b1, DW'(wv));
            if (acc) wv++;
        end
        chk("stream_groups", 64'(m_grp), 64'd257);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("stream_last_addr", 64'(bus.tw_addr), 64'd0);
        bus.in_valid = 1'b0;
        repeat (6) cyc(1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
